// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver: the loopback partner of the serializer.
// Optional partial-word flush after an idle gap is enabled by DESERIALIZER_GAP_FLUSH_EN.
module deserializer #(
  parameter int DATA_W     = 16,
  parameter int MOD_W      = $clog2(DATA_W),
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [MOD_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] bit_vec;
  logic [DATA_W-1:0] acc_with_bit;

`ifdef DESERIALIZER_GAP_FLUSH_EN
  logic [7:0] idle_q, idle_d;
`endif

  // Incoming bit lands at position DATA_W-1-cnt; acc is zero below the fill point.
  assign bit_vec      = {ser_data_i, {(DATA_W-1){1'b0}}} >> cnt_q;
  assign acc_with_bit = acc_q | bit_vec;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = 1'b0;
`ifdef DESERIALIZER_GAP_FLUSH_EN
    idle_d = idle_q;
`endif
    if (ser_data_val_i) begin
`ifdef DESERIALIZER_GAP_FLUSH_EN
      idle_d = 8'd0;
`endif
      if (cnt_q == MOD_W'(DATA_W-1)) begin
        data_d = acc_with_bit;
        mod_d  = '0;
        val_d  = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = acc_with_bit;
        cnt_d = cnt_q + MOD_W'(1);
      end
    end
`ifdef DESERIALIZER_GAP_FLUSH_EN
    else if (cnt_q != '0) begin
      if (idle_q == 8'(GAP_CYCLES-1)) begin
        // 1- and 2-bit fragments are never produced by the serializer: drop them.
        if (cnt_q >= MOD_W'(3)) begin
          data_d = acc_q;
          mod_d  = cnt_q;
          val_d  = 1'b1;
        end
        acc_d  = '0;
        cnt_d  = '0;
        idle_d = 8'd0;
      end else begin
        idle_d = idle_q + 8'd1;
      end
    end
`endif
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef DESERIALIZER_GAP_FLUSH_EN
      idle_q <= 8'd0;
`endif
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      mod_q  <= mod_d;
      val_q  <= val_d;
      busy_q <= busy_d;
`ifdef DESERIALIZER_GAP_FLUSH_EN
      idle_q <= idle_d;
`endif
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed loopback scenarios plus randomized bit streams
// compared cycle by cycle against a queue-based model of the receive rules.
module tb_deserializer;
  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);
  localparam int GAP    = 4;

  logic              clk_i = 1'b0;
  logic              srst_i = 1'b1;
  logic              ser_data_i = 1'b0;
  logic              ser_data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;

  deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .GAP_CYCLES(GAP)) dut (
    .clk_i           (clk_i),
    .srst_i          (srst_i),
    .ser_data_i      (ser_data_i),
    .ser_data_val_i  (ser_data_val_i),
    .deser_data_o    (deser_data_o),
    .deser_data_mod_o(deser_data_mod_o),
    .deser_data_val_o(deser_data_val_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int cycle = 0;
  int strobe_cycles[$];

  // Reference model: bits of the word in progress, and idle cycles since the last bit.
  bit                m_bits[$];
  int                m_gap = 0;
  logic [DATA_W-1:0] exp_data = '0;
  logic [MOD_W-1:0]  exp_mod = '0;
  logic              exp_val = 1'b0;
  logic              exp_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [DATA_W-1:0] pack_bits();
    logic [DATA_W-1:0] w = '0;
    foreach (m_bits[i]) w = {w[DATA_W-2:0], m_bits[i]};
    return w << (DATA_W - m_bits.size());
  endfunction

  task automatic model_update(input logic rst, input logic v, input logic b);
    exp_val = 1'b0;
    if (rst) begin
      m_bits.delete();
      m_gap = 0;
      exp_data = '0;
      exp_mod = '0;
    end else if (v) begin
      m_bits.push_back(b);
      m_gap = 0;
      if (m_bits.size() == DATA_W) begin
        exp_data = pack_bits();
        exp_mod = '0;
        exp_val = 1'b1;
        m_bits.delete();
      end
    end else if (m_bits.size() > 0) begin
`ifdef DESERIALIZER_GAP_FLUSH_EN
      m_gap++;
      if (m_gap == GAP) begin
        if (m_bits.size() >= 3) begin
          exp_data = pack_bits();
          exp_mod = MOD_W'(m_bits.size());
          exp_val = 1'b1;
        end
        m_bits.delete();
        m_gap = 0;
      end
`endif
    end
    exp_busy = (m_bits.size() != 0);
  endtask

  task automatic step(input logic rst, input logic v, input logic b);
    srst_i = rst;
    ser_data_val_i = v;
    ser_data_i = b;
    @(posedge clk_i);
    #1;
    cycle++;
    model_update(rst, v, b);
    check_eq("val", 32'(deser_data_val_o), 32'(exp_val));
    check_eq("busy", 32'(busy_o), 32'(exp_busy));
    check_eq("data", 32'(deser_data_o), 32'(exp_data));
    check_eq("mod", 32'(deser_data_mod_o), 32'(exp_mod));
    if (deser_data_val_o) begin
      strobes++;
      strobe_cycles.push_back(cycle);
      $display("strobe cycle=%0d data=0x%04h mod=%0d", cycle, deser_data_o, deser_data_mod_o);
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int s0;
    logic [DATA_W-1:0] w;
    logic [4:0] five;

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("rst_data", 32'(deser_data_o), 32'h0);
    check_eq("rst_val", 32'(deser_data_val_o), 32'h0);
    check_eq("rst_busy", 32'(busy_o), 32'h0);

    // Single word 0xA5C3
    s0 = strobes;
    w = 16'hA5C3;
    for (int i = DATA_W - 1; i >= 1; i--) step(1'b0, 1'b1, w[i]);
    check_eq("a5c3_busy_mid", 32'(busy_o), 32'h1);
    step(1'b0, 1'b1, w[0]);
    check_eq("a5c3_val", 32'(deser_data_val_o), 32'h1);
    check_eq("a5c3_data", 32'(deser_data_o), 32'hA5C3);
    check_eq("a5c3_mod", 32'(deser_data_mod_o), 32'h0);
    check_eq("a5c3_busy_end", 32'(busy_o), 32'h0);
    idle(2);
    check_eq("a5c3_strobes", 32'(strobes - s0), 32'd1);

    // Back-to-back words
    s0 = strobes;
    strobe_cycles.delete();
    send_word(16'hFFFF);
    check_eq("b2b_first", 32'(deser_data_o), 32'hFFFF);
    send_word(16'h0001);
    check_eq("b2b_second", 32'(deser_data_o), 32'h0001);
    check_eq("b2b_strobes", 32'(strobes - s0), 32'd2);
    if (strobe_cycles.size() == 2)
      check_eq("b2b_spacing", 32'(strobe_cycles[1] - strobe_cycles[0]), 32'd16);
    idle(2);

    // Five-bit fragment 1,0,1,1,0
    s0 = strobes;
    five = 5'b10110;
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, five[i]);
    idle(GAP - 1);
    check_eq("frag5_early", 32'(deser_data_val_o), 32'h0);
    idle(1);
`ifdef DESERIALIZER_GAP_FLUSH_EN
    check_eq("frag5_val", 32'(deser_data_val_o), 32'h1);
    check_eq("frag5_data", 32'(deser_data_o), 32'hB000);
    check_eq("frag5_mod", 32'(deser_data_mod_o), 32'd5);
    check_eq("frag5_busy", 32'(busy_o), 32'h0);
`else
    check_eq("frag5_hold", 32'(busy_o), 32'h1);
    step(1'b1, 1'b0, 1'b0);
`endif
    idle(2);

    // Two-bit fragment and an idle-only stretch never strobe
    s0 = strobes;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(GAP + 3);
`ifdef DESERIALIZER_GAP_FLUSH_EN
    check_eq("frag2_busy", 32'(busy_o), 32'h0);
`else
    check_eq("frag2_busy", 32'(busy_o), 32'h1);
    step(1'b1, 1'b0, 1'b0);
`endif
    idle(GAP + 3);
    check_eq("frag2_strobes", 32'(strobes - s0), 32'd0);

    // Reset mid-word
    s0 = strobes;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0);
    check_eq("abort_busy", 32'(busy_o), 32'h0);
    send_word(16'h1234);
    check_eq("abort_data", 32'(deser_data_o), 32'h1234);
    check_eq("abort_strobes", 32'(strobes - s0), 32'd1);
    idle(2);

    // Gap one short of the flush threshold inside a word
    s0 = strobes;
    w = 16'h8001;
    for (int i = DATA_W - 1; i >= 8; i--) step(1'b0, 1'b1, w[i]);
    idle(GAP - 1);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, w[i]);
    check_eq("gap_data", 32'(deser_data_o), 32'h8001);
    check_eq("gap_mod", 32'(deser_data_mod_o), 32'h0);
    check_eq("gap_strobes", 32'(strobes - s0), 32'd1);
    idle(2);

    // Randomized traffic: bursts, gaps of varying length, rare resets
    for (int n = 0; n < 400; n++) begin
      int mode = $urandom_range(0, 9);
      if (mode == 0) begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (mode < 6) begin
        int len = $urandom_range(1, 20);
        for (int i = 0; i < len; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        idle($urandom_range(1, GAP + 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the team's serializer. Accepts an MSB-first bit stream qualified by a valid strobe and reassembles it into left-aligned DATA_W-bit words. Each word is presented for one cycle with its bit count in the same encoding the serializer's `data_mod_i` uses. Sits directly after the serial link, so that serializer → deserializer forms a loopback pair.

## Interface
- DATA_W, 16: word width in bits.
- MOD_W, $clog2(DATA_W): width of the bit-count field.
- GAP_CYCLES, 4: idle cycles that close a partial word (gap-flush build only); legal range 1..255.

- clk_i  in  1  single clock; all logic on its rising edge.
- srst_i  in  1  reset; synchronous, active-high.
- ser_data_i  in  1  serial data bit, MSB first.
- ser_data_val_i  in  1  ser_data_i valid this cycle.
- deser_data_o  out  DATA_W  assembled word; first received bit at [DATA_W-1]; unused LSBs 0.
- deser_data_mod_o  out  MOD_W  valid bit count; 0 means DATA_W.
- deser_data_val_o  out  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o.
- busy_o  out  1  partial word held (bit count between 1 and DATA_W-1).

## Operation
- State: shift register `acc[DATA_W-1:0]`, bit counter `cnt` (0..DATA_W-1), idle counter `idle` (gap-flush build only).
- Accept: on a clock with ser_data_val_i=1, write ser_data_i to acc[DATA_W-1-cnt] and increment cnt.
- Full word: when the accepted bit is bit DATA_W:
  - register deser_data_o = completed acc, deser_data_mod_o = 0, deser_data_val_o = 1;
  - clear acc and cnt in the same edge.
- No stall and no ready signal. Every valid bit is consumed. Back-to-back words with no gap are supported without bit loss.
- Gap flush (macro on):
  - With cnt>0 and ser_data_val_i=0, idle increments.
  - Any valid bit clears idle.
  - When idle reaches GAP_CYCLES:
    - cnt ≥ 3: emit acc with deser_data_mod_o = cnt and deser_data_val_o = 1.
    - cnt = 1 or 2: discard silently with no strobe, because the serializer never sends 1- or 2-bit words.
  - In both cases clear acc, cnt and idle.
- deser_data_o and deser_data_mod_o hold their last emitted value between strobes.
- busy_o = (cnt != 0), registered.

## Timing
- Reset values: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0; acc, cnt and idle are also cleared.
- Full-word latency: the DATA_W-th bit is sampled at edge E. deser_data_val_o is high for exactly the cycle following E.
- Flush latency: the last bit is sampled at edge E0. The word is registered at edge E0+GAP_CYCLES, with valid high for the following cycle.
- Simultaneous events:
  - A valid bit arriving on the flush edge counts first. The word keeps growing and no flush occurs.
  - A bit on the cycle after a full-word emit becomes bit 0 of the next word.
- srst_i mid-word: the partial word is dropped with no strobe. The next valid bit after reset release is bit 0.
- Throughput: 1 bit per clock sustained.

## Configuration
- DESERIALIZER_GAP_FLUSH_EN
  - Defined: idle counter and partial-word flush present, and deser_data_mod_o reports lengths 3..DATA_W-1.
  - Undefined: no idle counter. Partial words wait indefinitely for more bits, and deser_data_mod_o is constant 0.

## Test plan
- Reset, then 16 contiguous valid bits of 0xA5C3 MSB first → one strobe on the cycle after the 16th bit: deser_data_o=0xA5C3, mod=0, busy_o 1→0.
- Two words 0xFFFF then 0x0001 back-to-back, 32 contiguous valid cycles → exactly two strobes 16 cycles apart, values 0xFFFF then 0x0001.
- Flush build: 5 bits 1,0,1,1,0 then idle → strobe GAP_CYCLES cycles after the last bit with data=0xB000, mod=5.
- Flush build: 2 bits then idle, and 0 bits with idle → no strobe ever; busy_o returns to 0 after GAP_CYCLES.
- 9 bits, then srst_i for 1 cycle, then 16 bits of 0x1234 → single strobe with 0x1234; nothing from the aborted 9 bits.
- Gap of GAP_CYCLES-1 idle cycles inside a 16-bit word 0x8001 → no flush; single full strobe 0x8001, mod=0.
